pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order MIPS pipeline; successor to the fixed 5-stage Hazard+Forward pair.
//  Tracks in-flight producers in a NSTAGES-deep scoreboard shift register (stage 1=EX .. NSTAGES=WB).
//  Drives decode stall, EX bubble and per-read-port forward selects; supports NRD read ports and per-op result latency.
// PARAMETERS
//  NSTAGES  3  tracked stages after ID (1=EX, 2=MEM, 3=WB); range 2..8
//  NRD      2  register read ports per instruction (rs, rt); range 1..4
//  AW       5  register address width; register 0 is hard-wired zero
//  LW       2  width of result-latency field
// PORTS
//  clk           in   1          clock
//  reset         in   1          async, active-low (0 = reset)
//  id_valid      in   1          valid instruction in ID
//  id_rs         in   NRD*AW     source register per port
//  id_rs_used    in   NRD        port actually reads a register
//  id_need_early in   NRD        1: operand needed in ID (branch/jr); 0: needed in EX
//  id_wr_en      in   1          instruction writes a register
//  id_wr_reg     in   AW         destination register
//  id_lat        in   LW         stages until result forwardable (ALU=1, load=2)
//  flush_id      in   1          squash instruction in ID
//  ext_stall     in   1          freeze whole pipeline (memory wait)
//  stall_id      out  1          hold PC and IF/ID
//  bubble_ex     out  1          issue NOP into ID/EX
//  id_fwd_sel    out  NRD*SELW   ID-operand source: 0=regfile, k=stage k
//  ex_fwd_sel    out  NRD*SELW   registered EX-operand source for instruction in EX
//  stage_valid   out  NSTAGES    scoreboard valid bits
//  perf_stall_cnt  out 32        hazard-stall cycles (see CONFIGURATION)
//  perf_bubble_cnt out 32        bubbles inserted
// BEHAVIOUR
//  Reset (async, reset=0): all entries invalid, ex_fwd_sel=0, counters=0; stall_id=ext_stall, bubble_ex=0.
//  Entry = {valid, wr_en, wr_reg, lat}. Every cycle with ext_stall=0 the scoreboard shifts one stage;
//   entry NSTAGES retires. New entry 1 = ID instruction if issued, else invalid (bubble).
//  Match: valid & wr_en & wr_reg==rs & rs!=0 & rs_used. Lowest stage index (youngest) wins.
//  Readiness: early operand ready if producer stage k > lat; EX operand ready if k >= lat.
//  hazard = id_valid & any used port whose youngest match is not ready.
//  stall_id = ext_stall | (hazard & ~flush_id); bubble_ex = ~ext_stall & (hazard | flush_id | ~id_valid).
//  id_fwd_sel (comb) = k of youngest ready match for early ports, else 0.
//  ex_fwd_sel registered at issue = k+1 of youngest match for EX ports (0 if none or k+1>NSTAGES); held on ext_stall; 0 on bubble.
//  flush_id with hazard: flush wins, no stall, bubble issued. ext_stall overrides all: no shift, counters frozen.
//  SELW = $clog2(NSTAGES+1). Counters wrap at 2^32.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined: perf_stall_cnt += 1 per cycle with hazard-stall (ext_stall=0);
//   perf_bubble_cnt += 1 per bubble_ex cycle. Undefined: both ports tied to 0, no flops.
// STRUCTURE
//  Package pipe_hazard_pkg: entry struct typedef, SELW constant function, LAT_ALU=1/LAT_LOAD=2 constants.
//  Sub-module pipe_hazard_match: one per read port; compare vs all entries, priority-encode youngest, output stage+ready.
// TESTING
//  1 add $8 then add using $8 (EX) -> no stall; next cycle ex_fwd_sel=2 (MEM).
//  2 lw $9 (lat=2) then add using $9 -> stall_id=1, bubble_ex=1 for 1 cycle; then ex_fwd_sel=3 (WB).
//  3 add $10 then beq on $10 (early) -> 1 stall cycle; then id_fwd_sel=2, stall_id=0.
//  4 producer writes $0, consumer reads $0 -> no stall, all selects 0.
//  5 ext_stall held 3 cycles during case 2 -> stage_valid frozen, stall_id=1; after release same result as case 2.
//  6 reset=0 mid-run -> stage_valid=0 immediately; counters 0; next dependent issue sees no hazard.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the parametrised pipeline hazard/forwarding unit.
package pipe_hazard_pkg;

  // Scoreboard fields are sized for the widest supported configuration.
  // Narrower register and latency fields are zero-extended into them.
  localparam int unsigned REG_AW_MAX = 8;
  localparam int unsigned LAT_W_MAX  = 4;

  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_AW_MAX-1:0] wr_reg;
    logic [LAT_W_MAX-1:0]  lat;
  } sb_entry_t;

  function automatic int unsigned sel_w(input int unsigned nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// Per-read-port comparator: finds the youngest in-flight producer of one source register
// and reports its stage and whether its result can already be forwarded.
module pipe_hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned AW      = 5,
  parameter int unsigned SELW    = 2
) (
  input  logic [AW-1:0]            rs,
  input  logic                     rs_used,
  input  logic                     need_early,
  input  sb_entry_t [NSTAGES-1:0]  entries,
  output logic                     hit,
  output logic [SELW-1:0]          stage,
  output logic                     ready
);

  logic [REG_AW_MAX-1:0] rs_ext;

  assign rs_ext = REG_AW_MAX'(rs);

  // Scan oldest to youngest so the lowest stage index overwrites older matches.
  always_comb begin
    hit   = 1'b0;
    stage = '0;
    ready = 1'b1;
    for (int i = int'(NSTAGES) - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].wr_en && (entries[i].wr_reg == rs_ext) &&
          (rs != '0) && rs_used) begin
        hit   = 1'b1;
        stage = SELW'(i + 1);
        ready = need_early ? ((i + 1) > int'(entries[i].lat))
                           : ((i + 1) >= int'(entries[i].lat));
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the in-order pipeline: scoreboard of in-flight producers,
// decode stall, EX bubble and forward selects. Optional counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned NRD     = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned LW      = 2,
  localparam int unsigned SELW   = sel_w(NSTAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [NRD*AW-1:0]     id_rs,
  input  logic [NRD-1:0]        id_rs_used,
  input  logic [NRD-1:0]        id_need_early,
  input  logic                  id_wr_en,
  input  logic [AW-1:0]         id_wr_reg,
  input  logic [LW-1:0]         id_lat,
  input  logic                  flush_id,
  input  logic                  ext_stall,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic [NRD*SELW-1:0]   id_fwd_sel,
  output logic [NRD*SELW-1:0]   ex_fwd_sel,
  output logic [NSTAGES-1:0]    stage_valid,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_bubble_cnt
);

  sb_entry_t [NSTAGES-1:0]   sb_q, sb_d;
  logic [NRD*SELW-1:0]       ex_fwd_q, ex_fwd_d, ex_fwd_issue;
  logic [NRD-1:0]            hit, ready, port_haz;
  logic [NRD-1:0][SELW-1:0]  stage;
  logic                      hazard, issue;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    pipe_hazard_match #(
      .NSTAGES (NSTAGES),
      .AW      (AW),
      .SELW    (SELW)
    ) u_match (
      .rs         (id_rs[p*AW +: AW]),
      .rs_used    (id_rs_used[p]),
      .need_early (id_need_early[p]),
      .entries    (sb_q),
      .hit        (hit[p]),
      .stage      (stage[p]),
      .ready      (ready[p])
    );

    assign port_haz[p] = hit[p] & ~ready[p];
    assign id_fwd_sel[p*SELW +: SELW] =
        (id_need_early[p] && hit[p] && ready[p]) ? stage[p] : '0;
    // The producer advances one stage while the consumer moves into EX; once it
    // has retired the regfile already holds the value.
    assign ex_fwd_issue[p*SELW +: SELW] =
        (!id_need_early[p] && hit[p] && (int'(stage[p]) < int'(NSTAGES))) ?
        stage[p] + SELW'(1) : '0;
  end

  assign hazard    = reset & id_valid & (|port_haz);
  assign stall_id  = ext_stall | (hazard & ~flush_id);
  assign bubble_ex = reset & ~ext_stall & (hazard | flush_id | ~id_valid);
  assign issue     = ~ext_stall & id_valid & ~hazard & ~flush_id;

  always_comb begin
    sb_d     = sb_q;
    ex_fwd_d = ex_fwd_q;
    if (!ext_stall) begin
      for (int i = int'(NSTAGES) - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0]  = '0;
      ex_fwd_d = '0;
      if (issue) begin
        sb_d[0].valid  = 1'b1;
        sb_d[0].wr_en  = id_wr_en;
        sb_d[0].wr_reg = REG_AW_MAX'(id_wr_reg);
        sb_d[0].lat    = LAT_W_MAX'(id_lat);
        ex_fwd_d       = ex_fwd_issue;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q     <= '0;
      ex_fwd_q <= '0;
    end else begin
      sb_q     <= sb_d;
      ex_fwd_q <= ex_fwd_d;
    end
  end

  assign ex_fwd_sel = ex_fwd_q;

  for (genvar s = 0; s < NSTAGES; s++) begin : g_valid
    assign stage_valid[s] = sb_q[s].valid;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (!ext_stall && hazard && !flush_id) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bubble_ex) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit in its default configuration.
module tb_pipe_hazard_unit;
  import pipe_hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used, id_need_early;
  logic       id_wr_en;
  logic [4:0] id_wr_reg;
  logic [1:0] id_lat;
  logic       flush_id, ext_stall;
  logic       stall_id, bubble_ex;
  logic [3:0] id_fwd_sel, ex_fwd_sel;
  logic [2:0] stage_valid;
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;

  int checks = 0;
  int passed = 0;

  localparam logic [1:0] LA = 2'(LAT_ALU);
  localparam logic [1:0] LL = 2'(LAT_LOAD);

  pipe_hazard_unit dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rs_used      (id_rs_used),
    .id_need_early   (id_need_early),
    .id_wr_en        (id_wr_en),
    .id_wr_reg       (id_wr_reg),
    .id_lat          (id_lat),
    .flush_id        (flush_id),
    .ext_stall       (ext_stall),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .id_fwd_sel      (id_fwd_sel),
    .ex_fwd_sel      (ex_fwd_sel),
    .stage_valid     (stage_valid),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used, input logic [1:0] early, input logic we,
                        input logic [4:0] wr, input logic [1:0] lat);
    id_valid      = v;
    id_rs         = {r1, r0};
    id_rs_used    = used;
    id_need_early = early;
    id_wr_en      = we;
    id_wr_reg     = wr;
    id_lat        = lat;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 5'd0, 2'd0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush_id = 1'b0;
    ext_stall = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 5'd0, 2'd0);
    #3;
    checks++; if (stage_valid !== 3'b000) $display("FAIL rst_valid: got %b want 000", stage_valid); else passed++;
    checks++; if (ex_fwd_sel !== 4'h0) $display("FAIL rst_exfwd: got %h want 0", ex_fwd_sel); else passed++;
    checks++; if (bubble_ex !== 1'b0) $display("FAIL rst_bubble: got %b want 0", bubble_ex); else passed++;
    checks++; if (stall_id !== 1'b0) $display("FAIL rst_stall0: got %b want 0", stall_id); else passed++;
    ext_stall = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b1) $display("FAIL rst_stall1: got %b want 1", stall_id); else passed++;
    checks++; if ({perf_stall_cnt, perf_bubble_cnt} !== 64'd0)
      $display("FAIL rst_cnt: got %h/%h want 0/0", perf_stall_cnt, perf_bubble_cnt); else passed++;
    ext_stall = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_alu_fwd();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 2'b00, 1'b1, 5'd8, LA);
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) $display("FAIL alu_issue: got %b want 00", {stall_id, bubble_ex}); else passed++;
    tick();
    checks++; if (stage_valid !== 3'b001) $display("FAIL alu_sv1: got %b want 001", stage_valid); else passed++;
    set_id(1'b1, 5'd8, 5'd3, 2'b11, 2'b00, 1'b1, 5'd11, LA);
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) $display("FAIL alu_nostall: got %b want 00", {stall_id, bubble_ex}); else passed++;
    checks++; if (id_fwd_sel !== 4'h0) $display("FAIL alu_idfwd: got %h want 0", id_fwd_sel); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'b0010) $display("FAIL alu_exfwd: got %b want 0010", ex_fwd_sel); else passed++;
    checks++; if (stage_valid !== 3'b011) $display("FAIL alu_sv2: got %b want 011", stage_valid); else passed++;
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd29, 5'd0, 2'b01, 2'b00, 1'b1, 5'd9, LL);
    tick();
    set_id(1'b1, 5'd4, 5'd9, 2'b11, 2'b00, 1'b1, 5'd12, LA);
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b11) $display("FAIL ld_stall: got %b want 11", {stall_id, bubble_ex}); else passed++;
    tick();
    checks++; if (stage_valid !== 3'b010) $display("FAIL ld_sv_bubble: got %b want 010", stage_valid); else passed++;
    checks++; if (ex_fwd_sel !== 4'h0) $display("FAIL ld_exfwd_bubble: got %b want 0000", ex_fwd_sel); else passed++;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) $display("FAIL ld_release: got %b want 00", {stall_id, bubble_ex}); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'b1100) $display("FAIL ld_exfwd_wb: got %b want 1100", ex_fwd_sel); else passed++;
    checks++; if (stage_valid !== 3'b101) $display("FAIL ld_sv: got %b want 101", stage_valid); else passed++;
    drain();
  endtask

  task automatic test_branch_early();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 2'b00, 1'b1, 5'd10, LA);
    tick();
    set_id(1'b1, 5'd10, 5'd5, 2'b11, 2'b11, 1'b0, 5'd0, LA);
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b11) $display("FAIL br_stall: got %b want 11", {stall_id, bubble_ex}); else passed++;
    checks++; if (id_fwd_sel !== 4'h0) $display("FAIL br_idfwd0: got %b want 0000", id_fwd_sel); else passed++;
    tick();
    checks++; if (stall_id !== 1'b0) $display("FAIL br_release: got %b want 0", stall_id); else passed++;
    checks++; if (id_fwd_sel !== 4'b0010) $display("FAIL br_idfwd_mem: got %b want 0010", id_fwd_sel); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'h0) $display("FAIL br_exfwd: got %b want 0000", ex_fwd_sel); else passed++;
    drain();
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 2'b00, 1'b1, 5'd0, LL);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 2'b01, 1'b1, 5'd7, LA);
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) $display("FAIL zero_stall: got %b want 00", {stall_id, bubble_ex}); else passed++;
    checks++; if (id_fwd_sel !== 4'h0) $display("FAIL zero_idfwd: got %b want 0000", id_fwd_sel); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'h0) $display("FAIL zero_exfwd: got %b want 0000", ex_fwd_sel); else passed++;
    drain();
  endtask

  task automatic test_youngest();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd13, LA);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd13, LL);
    tick();
    set_id(1'b1, 5'd13, 5'd0, 2'b01, 2'b00, 1'b1, 5'd17, LA);
    #1;
    checks++; if (stall_id !== 1'b1) $display("FAIL young_stall: got %b want 1", stall_id); else passed++;
    tick();
    checks++; if (stall_id !== 1'b0) $display("FAIL young_release: got %b want 0", stall_id); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'b0011) $display("FAIL young_exfwd: got %b want 0011", ex_fwd_sel); else passed++;
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd14, LL);
    tick();
    set_id(1'b1, 5'd14, 5'd0, 2'b01, 2'b00, 1'b1, 5'd18, LA);
    flush_id = 1'b1;
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b01) $display("FAIL flush_wins: got %b want 01", {stall_id, bubble_ex}); else passed++;
    tick();
    flush_id = 1'b0;
    checks++; if (stage_valid !== 3'b010) $display("FAIL flush_sv: got %b want 010", stage_valid); else passed++;
    drain();
  endtask

  task automatic test_wb_boundary();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd15, LA);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 5'd0, 2'd0);
    tick();
    tick();
    set_id(1'b1, 5'd15, 5'd15, 2'b11, 2'b10, 1'b1, 5'd19, LA);
    #1;
    checks++; if (stall_id !== 1'b0) $display("FAIL wb_stall: got %b want 0", stall_id); else passed++;
    checks++; if (id_fwd_sel !== 4'b1100) $display("FAIL wb_idfwd: got %b want 1100", id_fwd_sel); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'h0) $display("FAIL wb_exfwd: got %b want 0000", ex_fwd_sel); else passed++;
    drain();
  endtask

  task automatic test_ext_stall();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd16, LA);
    tick();
    set_id(1'b1, 5'd16, 5'd0, 2'b01, 2'b00, 1'b1, 5'd9, LL);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0010) $display("FAIL ext_pre_exfwd: got %b want 0010", ex_fwd_sel); else passed++;
    set_id(1'b1, 5'd4, 5'd9, 2'b11, 2'b00, 1'b1, 5'd12, LA);
    ext_stall = 1'b1;
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b10) $display("FAIL ext_stall_out: got %b want 10", {stall_id, bubble_ex}); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (stage_valid !== 3'b011) $display("FAIL ext_frozen_sv: got %b want 011", stage_valid); else passed++;
      checks++; if (ex_fwd_sel !== 4'b0010) $display("FAIL ext_held_exfwd: got %b want 0010", ex_fwd_sel); else passed++;
    end
    ext_stall = 1'b0;
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b11) $display("FAIL ext_ld_stall: got %b want 11", {stall_id, bubble_ex}); else passed++;
    tick();
    checks++; if (stage_valid !== 3'b110) $display("FAIL ext_sv_bubble: got %b want 110", stage_valid); else passed++;
    checks++; if (stall_id !== 1'b0) $display("FAIL ext_release: got %b want 0", stall_id); else passed++;
    tick();
    checks++; if (ex_fwd_sel !== 4'b1100) $display("FAIL ext_exfwd_wb: got %b want 1100", ex_fwd_sel); else passed++;
    drain();
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 5'd29, 5'd0, 2'b01, 2'b00, 1'b1, 5'd9, LL);
    tick();
    set_id(1'b1, 5'd4, 5'd9, 2'b11, 2'b00, 1'b1, 5'd12, LA);
    #1;
    checks++; if (stall_id !== 1'b1) $display("FAIL mid_pre_stall: got %b want 1", stall_id); else passed++;
    #1 reset = 1'b0;
    #1;
    checks++; if (stage_valid !== 3'b000) $display("FAIL mid_sv: got %b want 000", stage_valid); else passed++;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) $display("FAIL mid_outs: got %b want 00", {stall_id, bubble_ex}); else passed++;
    checks++; if ({perf_stall_cnt, perf_bubble_cnt} !== 64'd0)
      $display("FAIL mid_cnt: got %h/%h want 0/0", perf_stall_cnt, perf_bubble_cnt); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if ({stall_id, bubble_ex} !== 2'b00) $display("FAIL mid_nohaz: got %b want 00", {stall_id, bubble_ex}); else passed++;
    tick();
    checks++; if (stage_valid !== 3'b001) $display("FAIL mid_issue_sv: got %b want 001", stage_valid); else passed++;
    drain();
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall, exp_bubble;
`ifdef PIPE_HAZARD_PERF_EN
    exp_stall  = 32'd1;
    exp_bubble = 32'd2;
`else
    exp_stall  = 32'd0;
    exp_bubble = 32'd0;
`endif
    reset = 1'b0;
    set_id(1'b1, 5'd29, 5'd0, 2'b01, 2'b00, 1'b1, 5'd9, LL);
    #2 reset = 1'b1;
    tick();
    set_id(1'b1, 5'd4, 5'd9, 2'b11, 2'b00, 1'b1, 5'd12, LA);
    tick();
    tick();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 5'd0, 2'd0);
    ext_stall = 1'b1;
    tick();
    ext_stall = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd20, LA);
    flush_id = 1'b1;
    tick();
    flush_id = 1'b0;
    ext_stall = 1'b1;
    #1;
    checks++; if (perf_stall_cnt !== exp_stall) $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, exp_stall); else passed++;
    checks++; if (perf_bubble_cnt !== exp_bubble) $display("FAIL perf_bubble: got %0d want %0d", perf_bubble_cnt, exp_bubble); else passed++;
    ext_stall = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch_early();
    test_zero_reg();
    test_youngest();
    test_flush();
    test_wb_boundary();
    test_ext_stall();
    test_reset_mid();
    test_perf();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
